// File: rtl/bmd_256_latency_reader.sv
// Latency-check read side: issues BRAM reads for arriving slots, computes arrival - send,
// and keeps min/max/saturating-sum/count statistics of the error-free samples.
module bmd_256_latency_reader #(
    parameter int ADDR_W = 14,
    parameter int TS_W   = 64,
    parameter int RD_LAT = 2,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stat_clear,
    input  logic [TS_W-1:0]   latency_counter,
    input  logic              rx_arrive,
    input  logic [ADDR_W-1:0] rx_addr,
    output logic              bram_reb,
    output logic [ADDR_W-1:0] bram_rd_addr,
    input  logic [TS_W-1:0]   bram_rd_data,
    output logic              lat_valid,
    output logic [ADDR_W-1:0] lat_addr,
    output logic [TS_W-1:0]   lat_value,
    output logic              lat_err,
    output logic [TS_W-1:0]   lat_min,
    output logic [TS_W-1:0]   lat_max,
    output logic [TS_W-1:0]   lat_sum,
    output logic [CNT_W-1:0]  lat_count
);

    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [ADDR_W-1:0] addr_q [RD_LAT];
    logic [ADDR_W-1:0] addr_d [RD_LAT];
    logic [TS_W-1:0]   arr_q  [RD_LAT];
    logic [TS_W-1:0]   arr_d  [RD_LAT];

    logic              lat_valid_q, lat_valid_d;
    logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
    logic [TS_W-1:0]   lat_value_q, lat_value_d;
    logic              lat_err_q, lat_err_d;
    logic [TS_W-1:0]   lat_min_q, lat_min_d;
    logic [TS_W-1:0]   lat_max_q, lat_max_d;
    logic [TS_W-1:0]   lat_sum_q, lat_sum_d;
    logic [CNT_W-1:0]  lat_count_q, lat_count_d;
    logic [TS_W:0]     sum_ext_s;

    // Read issue is a pass-through, held quiet while reset is asserted
    assign bram_reb     = rx_arrive & ~rst;
    assign bram_rd_addr = rst ? '0 : rx_addr;

    // Carry pipeline: arrival stamp and slot travel alongside the BRAM read
    always_comb begin
        vld_d     = '0;
        vld_d[0]  = rx_arrive;
        addr_d[0] = rx_addr;
        arr_d[0]  = latency_counter;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i]  = vld_q[i-1];
            addr_d[i] = addr_q[i-1];
            arr_d[i]  = arr_q[i-1];
        end
    end

    // Carry pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                addr_q[i] <= '0;
                arr_q[i]  <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            addr_q <= addr_d;
            arr_q  <= arr_d;
        end
    end

    // Compute stage: modular difference; a zero stamp marks an unwritten slot
    always_comb begin
        lat_valid_d = vld_q[RD_LAT-1];
        lat_addr_d  = lat_addr_q;
        lat_value_d = lat_value_q;
        lat_err_d   = lat_err_q;
        if (vld_q[RD_LAT-1]) begin
            lat_addr_d  = addr_q[RD_LAT-1];
            lat_value_d = arr_q[RD_LAT-1] - bram_rd_data;
            lat_err_d   = (bram_rd_data == '0);
        end else begin
            lat_err_d   = lat_err_q;
        end
    end

    // Statistics: clear wins over a coincident sample
    always_comb begin
        sum_ext_s   = {1'b0, lat_sum_q} + {1'b0, lat_value_q};
        lat_min_d   = lat_min_q;
        lat_max_d   = lat_max_q;
        lat_sum_d   = lat_sum_q;
        lat_count_d = lat_count_q;
        if (stat_clear) begin
            lat_min_d   = '1;
            lat_max_d   = '0;
            lat_sum_d   = '0;
            lat_count_d = '0;
        end else if (lat_valid_q && !lat_err_q) begin
            lat_min_d   = (lat_value_q < lat_min_q) ? lat_value_q : lat_min_q;
            lat_max_d   = (lat_value_q > lat_max_q) ? lat_value_q : lat_max_q;
            lat_sum_d   = sum_ext_s[TS_W] ? '1 : sum_ext_s[TS_W-1:0];
            lat_count_d = (lat_count_q == '1) ? lat_count_q : lat_count_q + CNT_W'(1);
        end else begin
            lat_count_d = lat_count_q;
        end
    end

    // Result and statistics registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_valid_q <= 1'b0;
            lat_addr_q  <= '0;
            lat_value_q <= '0;
            lat_err_q   <= 1'b0;
            lat_min_q   <= '1;
            lat_max_q   <= '0;
            lat_sum_q   <= '0;
            lat_count_q <= '0;
        end else begin
            lat_valid_q <= lat_valid_d;
            lat_addr_q  <= lat_addr_d;
            lat_value_q <= lat_value_d;
            lat_err_q   <= lat_err_d;
            lat_min_q   <= lat_min_d;
            lat_max_q   <= lat_max_d;
            lat_sum_q   <= lat_sum_d;
            lat_count_q <= lat_count_d;
        end
    end

    assign lat_valid = lat_valid_q;
    assign lat_addr  = lat_addr_q;
    assign lat_value = lat_value_q;
    assign lat_err   = lat_err_q;
    assign lat_min   = lat_min_q;
    assign lat_max   = lat_max_q;
    assign lat_sum   = lat_sum_q;
    assign lat_count = lat_count_q;

endmodule

// File: tb/tb_bmd_256_latency_reader.sv
// Bench for bmd_256_latency_reader: BRAM emulation, queue-based result model,
// per-cycle compare, directed scenarios plus a randomized phase.
module tb_bmd_256_latency_reader;

    localparam int ADDR_W = 14;
    localparam int TS_W   = 64;
    localparam int RD_LAT = 2;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              stat_clear;
    logic [TS_W-1:0]   latency_counter;
    logic              rx_arrive;
    logic [ADDR_W-1:0] rx_addr;
    logic              bram_reb;
    logic [ADDR_W-1:0] bram_rd_addr;
    logic [TS_W-1:0]   bram_rd_data;
    logic              lat_valid;
    logic [ADDR_W-1:0] lat_addr;
    logic [TS_W-1:0]   lat_value;
    logic              lat_err;
    logic [TS_W-1:0]   lat_min, lat_max, lat_sum;
    logic [CNT_W-1:0]  lat_count;

    bmd_256_latency_reader #(.ADDR_W(ADDR_W), .TS_W(TS_W), .RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stat_clear(stat_clear), .latency_counter(latency_counter),
        .rx_arrive(rx_arrive), .rx_addr(rx_addr), .bram_reb(bram_reb), .bram_rd_addr(bram_rd_addr),
        .bram_rd_data(bram_rd_data), .lat_valid(lat_valid), .lat_addr(lat_addr),
        .lat_value(lat_value), .lat_err(lat_err), .lat_min(lat_min), .lat_max(lat_max),
        .lat_sum(lat_sum), .lat_count(lat_count)
    );

    always #2 clk = ~clk;

    // BRAM port B: registered read, two cycles of latency
    bit [TS_W-1:0] mem [0:(1<<ADDR_W)-1];
    bit [TS_W-1:0] p1, p2;
    always @(posedge clk) begin
        if (bram_reb) p1 <= mem[bram_rd_addr];
        p2 <= p1;
    end
    assign bram_rd_data = p2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            due;
        bit [ADDR_W-1:0] addr;
        bit [TS_W-1:0] val;
        bit            err;
    } exp_t;
    exp_t q[$];

    bit [TS_W-1:0]  m_min = '1, m_max = '0, m_sum = '0;
    bit [CNT_W-1:0] m_cnt = '0;
    bit [TS_W-1:0]  tcount;
    int n_checks = 0, n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_min = '1; m_max = '0; m_sum = '0; m_cnt = '0;
    endtask

    // Compare process: every cycle, outputs against the model
    always @(negedge clk) begin
        bit upd;
        bit [TS_W-1:0] v;
        bit [TS_W:0] t;
        upd = 1'b0;
        v = '0;
        if (rst) begin
            chk("rst_valid", lat_valid, 0);
            chk("rst_addr", lat_addr, 0);
            chk("rst_value", lat_value, 0);
            chk("rst_err", lat_err, 0);
            chk("rst_min", lat_min, 64'hFFFF_FFFF_FFFF_FFFF);
            chk("rst_max", lat_max, 0);
            chk("rst_sum", lat_sum, 0);
            chk("rst_count", lat_count, 0);
            chk("rst_reb", bram_reb, 0);
            chk("rst_rdaddr", bram_rd_addr, 0);
            q.delete();
            model_clear();
        end else begin
            chk("min", lat_min, m_min);
            chk("max", lat_max, m_max);
            chk("sum", lat_sum, m_sum);
            chk("count", lat_count, m_cnt);
            chk("reb", bram_reb, rx_arrive);
            chk("rd_addr", bram_rd_addr, rx_addr);
            if (q.size() > 0 && q[0].due == cyc) begin
                chk("valid", lat_valid, 1);
                chk("lat_addr", lat_addr, q[0].addr);
                chk("lat_value", lat_value, q[0].val);
                chk("lat_err", lat_err, q[0].err);
                upd = !q[0].err;
                v = q[0].val;
                void'(q.pop_front());
            end else begin
                chk("no_valid", lat_valid, 0);
            end
            if (stat_clear) begin
                model_clear();
            end else if (upd) begin
                if (v < m_min) m_min = v;
                if (v > m_max) m_max = v;
                t = {1'b0, m_sum} + {1'b0, v};
                m_sum = t[TS_W] ? '1 : t[TS_W-1:0];
                if (m_cnt != '1) m_cnt = m_cnt + 1;
            end
        end
    end

    task automatic step(input bit arr, input bit [ADDR_W-1:0] a, input bit clr);
        exp_t e;
        @(posedge clk); #1;
        rx_arrive = arr;
        rx_addr = a;
        stat_clear = clr;
        latency_counter = tcount;
        if (arr) begin
            e.due  = cyc + RD_LAT + 1;
            e.addr = a;
            e.val  = tcount - mem[a];
            e.err  = (mem[a] == '0);
            q.push_back(e);
        end
        tcount = tcount + 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; stat_clear = 1'b0; rx_arrive = 1'b0; rx_addr = '0;
        latency_counter = '0; tcount = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single sample
        mem[5] = 64'd100; tcount = 64'd130;
        step(1'b1, 14'd5, 1'b0); idle(4);
        chk("single_min", lat_min, 64'd30);
        chk("single_max", lat_max, 64'd30);
        chk("single_sum", lat_sum, 64'd30);
        chk("single_cnt", lat_count, 32'd1);

        // Back-to-back arrivals
        step(1'b0, '0, 1'b1);
        mem[1] = 64'd10; mem[2] = 64'd20; mem[3] = 64'd30; tcount = 64'd50;
        step(1'b1, 14'd1, 1'b0); step(1'b1, 14'd2, 1'b0); step(1'b1, 14'd3, 1'b0);
        idle(4);
        chk("b2b_min", lat_min, 64'd22);
        chk("b2b_max", lat_max, 64'd40);
        chk("b2b_sum", lat_sum, 64'd93);
        chk("b2b_cnt", lat_count, 32'd3);

        // Unwritten slot is reported but not accumulated
        mem[7] = '0;
        step(1'b1, 14'd7, 1'b0); idle(4);
        chk("unwr_cnt", lat_count, 32'd3);
        chk("unwr_sum", lat_sum, 64'd93);

        // Counter wrap between stamp and arrival
        step(1'b0, '0, 1'b1);
        mem[9] = 64'hFFFF_FFFF_FFFF_FFF0; tcount = 64'h10;
        step(1'b1, 14'd9, 1'b0); idle(4);
        chk("wrap_sum", lat_sum, 64'h20);
        chk("wrap_cnt", lat_count, 32'd1);

        // Clear coincident with a result of 7
        mem[11] = 64'd100; tcount = 64'd107;
        step(1'b1, 14'd11, 1'b0); idle(2); step(1'b0, '0, 1'b1); idle(2);
        chk("clr_cnt", lat_count, 32'd0);
        chk("clr_min", lat_min, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("clr_sum", lat_sum, 64'd0);
        mem[12] = 64'd100; tcount = 64'd109;
        step(1'b1, 14'd12, 1'b0); idle(4);
        chk("after_clr_min", lat_min, 64'd9);
        chk("after_clr_max", lat_max, 64'd9);
        chk("after_clr_sum", lat_sum, 64'd9);
        chk("after_clr_cnt", lat_count, 32'd1);

        // Sum saturation
        step(1'b0, '0, 1'b1);
        mem[13] = 64'd1; tcount = 64'd0;
        step(1'b1, 14'd13, 1'b0);
        tcount = 64'd0;
        step(1'b1, 14'd13, 1'b0); idle(4);
        chk("sat_sum", lat_sum, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("sat_cnt", lat_count, 32'd2);

        // Reset one cycle after an arrival
        mem[5] = 64'd100; tcount = 64'd200;
        step(1'b1, 14'd5, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1; rx_arrive = 1'b0; stat_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(6);
        chk("post_rst_cnt", lat_count, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 32; i++)
            mem[i] = (i % 5 == 0) ? 64'd0 : {$urandom, $urandom};
        tcount = {$urandom, $urandom};
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) tcount = {$urandom, $urandom};
            step($urandom_range(0, 3) != 0, 14'($urandom_range(0, 31)), $urandom_range(0, 39) == 0);
        end
        idle(6);
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/bmd_256_latency_reader.md
Name: bmd_256_latency_reader

Overview:
- Read/compute end of the latency-check BRAM. TX_ENGINE writes the send timestamp (latency_counter value) at a slot address.
- When RX_ENGINE reports the matching packet's arrival, this block reads that slot and samples the arrival time.
- It then emits latency = arrival − send and keeps min/max/sum/count statistics for VIO/ILA readout.
- Fully pipelined: accepts one arrival per cycle and drives the BRAM port B read signals.

Parameters:
- ADDR_W, 14, BRAM slot address width
- TS_W, 64, timestamp/latency width
- RD_LAT, 2, BRAM port B read latency in cycles (fixed by the BRAM configuration)
- CNT_W, 32, sample counter width

Ports:
- clk  in  1  250 MHz clock; BRAM and latency_counter share this clock
- rst  in  1  asynchronous, active-high reset
- stat_clear  in  1  synchronous user clear of the statistics (from RX_ENGINE/VIO)
- latency_counter  in  TS_W  free-running time base
- rx_arrive  in  1  arrival strobe from RX_ENGINE, one slot per cycle
- rx_addr  in  ADDR_W  slot address of the arriving packet
- bram_reb  out  1  BRAM port B read enable
- bram_rd_addr  out  ADDR_W  BRAM port B address
- bram_rd_data  in  TS_W  BRAM port B data, valid RD_LAT cycles after bram_reb
- lat_valid  out  1  one-cycle result strobe
- lat_addr  out  ADDR_W  slot address of the result
- lat_value  out  TS_W  arrival − send, modulo 2^TS_W
- lat_err  out  1  qualifies lat_valid: stored timestamp was zero (unwritten or reset slot)
- lat_min  out  TS_W  minimum valid latency
- lat_max  out  TS_W  maximum valid latency
- lat_sum  out  TS_W  saturating sum of valid latencies
- lat_count  out  CNT_W  saturating number of valid samples

Behaviour:
- Reset values:
  - bram_reb=0, bram_rd_addr=0, lat_valid=0, lat_addr=0, lat_value=0, lat_err=0.
  - lat_min=all-ones, lat_max=0, lat_sum=0, lat_count=0.
  - All pipeline valid bits cleared.
- Issue stage: bram_reb=rx_arrive and bram_rd_addr=rx_addr, combinational pass-through.
- Same cycle as issue: latency_counter is sampled into the pipeline as the arrival time.
- Carry pipeline: {valid, addr, arrival} is delayed RD_LAT cycles, aligned with bram_rd_data.
- Compute stage (registered): when the aligned valid bit is 1:
  - lat_value = arrival − bram_rd_data, modulo 2^TS_W.
  - lat_err = (bram_rd_data == 0).
  - lat_valid pulses, and lat_addr carries the slot address.
- Total latency: rx_arrive at cycle N gives lat_valid at cycle N+RD_LAT+1 (N+3 by default).
- Throughput: back-to-back arrivals give back-to-back results; there is no stall and no ready signal.
- Statistics update (registered): on lat_valid & !lat_err & !stat_clear, in the cycle after lat_valid:
  - lat_min = min(lat_min, lat_value); lat_max = max(lat_max, lat_value).
  - lat_sum += lat_value, saturating at 2^TS_W−1.
  - lat_count += 1, saturating at 2^CNT_W−1.
- Error samples: results with lat_err=1 are emitted but excluded from the statistics.
- stat_clear:
  - Returns the statistics to their reset values on the next edge.
  - Has priority over a coincident update, so that sample is dropped from the statistics.
  - Does not flush the pipeline; in-flight results still appear on lat_valid and are accumulated if they arrive after the clear.
- Wrap-around: the subtraction is modular. A counter wrap between stamp and arrival yields the correct small latency.
- Same-slot reuse: an arrival for slot A in the same cycle TS write to A is not this block's concern; the BRAM is write-first on port A.
- Asynchronous rst mid-operation:
  - All in-flight samples are discarded.
  - No lat_valid is asserted until a new rx_arrive has propagated through the pipeline.

Test Plan:
- Single sample: rst deasserts, BRAM slot 5 holds 100, rx_arrive with addr=5 at latency_counter=130.
  - lat_valid exactly 3 cycles later, lat_addr=5, lat_value=30, lat_err=0.
  - Next cycle: lat_min=lat_max=lat_sum=30, lat_count=1.
- Back-to-back arrivals: slots 1, 2, 3 hold 10, 20, 30; arrivals on consecutive cycles at counters 50, 51, 52.
  - Three consecutive lat_valid pulses with values 40, 31, 22.
  - Then min=22, max=40, sum=93, count=3.
- Unwritten slot: slot holds 0.
  - lat_valid=1 with lat_err=1; statistics unchanged.
- Wrap-around: stored 0xFFFF_FFFF_FFFF_FFF0, arrival counter 0x10.
  - lat_value=0x20, accumulated normally.
- stat_clear coincident with a lat_valid (value 7) after prior samples:
  - Statistics return to all-ones/0/0/0; that sample is not counted.
  - A following sample of 9 gives min=max=sum=9, count=1.
- rst asserted 1 cycle after rx_arrive:
  - No lat_valid ever appears for that arrival; all outputs return to their reset values immediately.
